// File: rtl/riscv_pkg.sv
// riscv_pkg: types and defaults shared by the memory-side blocks.
package riscv_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
   localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data ports,
// favouring data accesses while bounding how long a pending fetch can wait.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [DATA_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_be,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
   arb_state_t state, state_nx;
   logic [CW-1:0] starve_cnt, starve_nx;
   logic grant_i, grant_d;
   always_comb begin
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      state_nx  = state;
      starve_nx = starve_cnt;
      if (state == IDLE) begin
         grant_i   = i_req && (!d_req || starve_cnt == SMAX);
         grant_d   = d_req && !grant_i;
         state_nx  = grant_i ? BUSY_I : grant_d ? BUSY_D : IDLE;
         starve_nx = (grant_i || !i_req) ? '0 : (starve_cnt == SMAX) ? starve_cnt : starve_cnt + CW'(1);
      end else if (mem_ack) begin
         state_nx = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
      end else begin
         state      <= state_nx;
         starve_cnt <= starve_nx;
         if (grant_i) begin
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_be    <= 4'hF;
         end else if (grant_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
         end
      end
   end
   // mem_req follows the registered state, so reset drops it without waiting for an edge
   assign mem_req = state != IDLE;
   assign i_ack   = state == BUSY_I && mem_ack;
   assign d_ack   = state == BUSY_D && mem_ack;
   assign i_rdata = i_ack ? mem_rdata : '0;
   assign d_rdata = d_ack ? mem_rdata : '0;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data buses and the address buses.
REQ-002 Parameter STARVE_MAX, default 4: consecutive D-port grants allowed while the I-port is pending.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  1  fetch request; held with i_addr until i_ack.
REQ-006 i_addr  input  DATA_WIDTH  fetch byte address.
REQ-007 i_ack  output  1  fetch complete; one-cycle pulse.
REQ-008 i_rdata  output  DATA_WIDTH  fetched word; valid when i_ack=1.
REQ-009 d_req  input  1  data request; held with d_we, d_addr, d_wdata, d_be until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  DATA_WIDTH  data byte address.
REQ-012 d_wdata  input  DATA_WIDTH  store data.
REQ-013 d_be  input  4  byte enables.
REQ-014 d_ack  output  1  data access complete; one-cycle pulse.
REQ-015 d_rdata  output  DATA_WIDTH  load data; valid when d_ack=1.
REQ-016 mem_req  output  1  request to the single-port memory.
REQ-017 mem_we, mem_addr, mem_wdata, mem_be  output  1/DATA_WIDTH/DATA_WIDTH/4  registered copy of the granted request.
REQ-018 mem_ack  input  1  memory completion; may arrive 1..N cycles after mem_req rises.
REQ-019 mem_rdata  input  DATA_WIDTH  memory read data; valid with mem_ack.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-021 In IDLE with no request, the FSM SHALL stay in IDLE with mem_req=0.
REQ-022 In IDLE with exactly one request pending, the FSM SHALL grant that requester on the next edge.
REQ-023 In IDLE with both requests pending, the FSM SHALL grant D, except when starve_cnt==STARVE_MAX, in which case it SHALL grant I.
REQ-024 On a grant, the FSM SHALL register the granted port's fields into mem_* and set mem_req=1 in the following cycle; I-grants drive mem_we=0 and mem_be=4'hF.
REQ-025 In BUSY_x, mem_req and mem_* SHALL remain stable until mem_ack is sampled at 1.
REQ-026 In BUSY_x with mem_ack=1: x_ack SHALL be 1 combinationally in that cycle, x_rdata SHALL equal mem_rdata, and the FSM SHALL return to IDLE with mem_req=0 on the next edge.
REQ-027 Minimum request-to-ack latency SHALL be 2 cycles (grant edge, then ack with mem_ack=1); there SHALL be one idle cycle between back-to-back transactions.
REQ-028 starve_cnt: increments on a D-grant while i_req=1, saturating at STARVE_MAX; clears on any I-grant or when i_req=0 in IDLE.
REQ-029 An ack for the non-granted port SHALL never be asserted; i_ack and d_ack SHALL be mutually exclusive.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 Deassertion of a requester's req while it is granted (protocol violation) SHALL NOT abort the transaction; its ack still pulses.
REQ-032 i_rdata and d_rdata SHALL be 0 when the corresponding ack is 0.

Reset
REQ-033 While rst=1: state=IDLE, starve_cnt=0, mem_req=0, all mem_* outputs=0, i_ack=d_ack=0.
REQ-034 Reset asserted mid-transaction SHALL drop mem_req immediately and discard the transaction; no ack SHALL be issued for it.
REQ-035 After rst deasserts, the first grant SHALL occur no earlier than the first posedge at which a request is sampled.

Structure
REQ-036 The state enum (IDLE, BUSY_I, BUSY_D) and the default STARVE_MAX SHALL live in the shared package riscv_pkg.
REQ-037 The block SHALL be a single module with no sub-modules.
REQ-038 The block SHALL sit between instr_mem/data_mem users and a unified memory, replacing the separate ports.

Verification
REQ-039 Reset, then i_req=1 with i_addr=0xBFC00000 and mem_ack 1 cycle after mem_req -> mem_addr=0xBFC00000, mem_we=0; i_ack pulses 2 cycles after i_req with i_rdata=mem_rdata.
REQ-040 i_req and d_req both rise together, d_we=1, d_addr=0x100, d_be=4'b0011 -> D granted first (mem_be=0011); I granted after d_ack plus one idle cycle.
REQ-041 d_req held continuously with i_req=1, STARVE_MAX=4 -> exactly 4 D transactions, then an I transaction, then starve_cnt=0.
REQ-042 mem_ack delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles; a single one-cycle ack.
REQ-043 rst pulsed in BUSY_D before mem_ack -> mem_req=0 at once, no d_ack; a new d_req after reset completes normally.
REQ-044 Spurious mem_ack in IDLE -> no i_ack/d_ack, state unchanged.
